// File: rtl/aes32_pkg.sv
// Shared definitions for the 32-bit AES round sequencer: FSM states,
// legal round counts and the column width.
package aes32_pkg;

   localparam int COL_W  = 32;
   localparam int NR_128 = 10;
   localparam int NR_192 = 12;
   localparam int NR_256 = 14;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ROUND = 2'd1,
      OUT   = 2'd2
   } state_t;

endpackage

// File: rtl/aes32_round_sequencer.sv
// Column-serial AES block sequencer: loads four 32-bit columns, commits NR rounds
// from an external combinational round datapath, then streams the four result columns.
module aes32_round_sequencer
   import aes32_pkg::*;
#(
   parameter int NR = NR_128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [COL_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [COL_W-1:0] out_data,
   output logic [COL_W-1:0] st_0,
   output logic [COL_W-1:0] st_1,
   output logic [COL_W-1:0] st_2,
   output logic [COL_W-1:0] st_3,
   input  logic [COL_W-1:0] rd_0,
   input  logic [COL_W-1:0] rd_1,
   input  logic [COL_W-1:0] rd_2,
   input  logic [COL_W-1:0] rd_3,
   output logic [3:0]       rnd_idx,
   output logic             rnd_en,
   output logic             last_round,
   output logic             busy
);

   localparam logic [3:0] NR_IDX = 4'(NR);

   state_t           state_reg;
   state_t           state_next;
   logic [1:0]       beat_reg;
   logic [3:0]       rnd_idx_reg;
   logic [COL_W-1:0] st_col [4];
   logic [COL_W-1:0] rd_col [4];
   logic             accept;
   logic             emit;

   assign rd_col = '{rd_0, rd_1, rd_2, rd_3};
   assign accept = in_valid && in_ready;
   assign emit   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= LOAD;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         LOAD:    if (accept && beat_reg == 2'd3) state_next = ROUND;
         ROUND:   if (rnd_idx_reg == NR_IDX) state_next = OUT;
         OUT:     if (emit && beat_reg == 2'd3) state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rnd_en    = 1'b0;
      busy      = 1'b0;
      unique case (state_reg)
         LOAD:    in_ready = 1'b1;
         ROUND:   begin
            rnd_en = 1'b1;
            busy   = 1'b1;
         end
         OUT:     begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
      last_round = rnd_en && (rnd_idx_reg == NR_IDX);
      out_data   = out_valid ? st_col[beat_reg] : '0;
   end

   // One beat counter serves both the load and the unload phase; they never overlap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_reg <= '0;
      end else if (accept || emit) begin
         beat_reg <= beat_reg + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rnd_idx_reg <= '0;
      end else if (accept && beat_reg == 2'd3) begin
         rnd_idx_reg <= 4'd1;
      end else if (rnd_en) begin
         rnd_idx_reg <= (rnd_idx_reg == NR_IDX) ? 4'd0 : rnd_idx_reg + 4'd1;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic [COL_W-1:0] col_reg;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            col_reg <= '0;
         end else if (accept && beat_reg == 2'(gi)) begin
            col_reg <= in_data;
         end else if (rnd_en) begin
            col_reg <= rd_col[gi];
         end
      end

      assign st_col[gi] = col_reg;
   end

   assign st_0    = st_col[0];
   assign st_1    = st_col[1];
   assign st_2    = st_col[2];
   assign st_3    = st_col[3];
   assign rnd_idx = rnd_idx_reg;

endmodule

// File: tb/tb_aes32_round_sequencer.sv
// Self-checking bench: an NR=10 and an NR=14 sequencer, each closed by an XOR round stub,
// driven with directed vectors and randomized blocks against a plain XOR-accumulation model.
module tb_aes32_round_sequencer;

   typedef logic [31:0] word4_t [4];

   logic        clk = 1'b0;
   logic        rst_n      [2];
   logic        in_valid   [2];
   logic        in_ready   [2];
   logic [31:0] in_data    [2];
   logic        out_valid  [2];
   logic        out_ready  [2];
   logic [31:0] out_data   [2];
   logic [31:0] st         [2][4];
   logic [31:0] rd         [2][4];
   logic [3:0]  rnd_idx    [2];
   logic        rnd_en     [2];
   logic        last_round [2];
   logic        busy       [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   aes32_round_sequencer #(.NR(10)) u_dut10 (
      .clk(clk), .rst_n(rst_n[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .st_0(st[0][0]), .st_1(st[0][1]), .st_2(st[0][2]), .st_3(st[0][3]),
      .rd_0(rd[0][0]), .rd_1(rd[0][1]), .rd_2(rd[0][2]), .rd_3(rd[0][3]),
      .rnd_idx(rnd_idx[0]), .rnd_en(rnd_en[0]), .last_round(last_round[0]), .busy(busy[0])
   );

   aes32_round_sequencer #(.NR(14)) u_dut14 (
      .clk(clk), .rst_n(rst_n[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .st_0(st[1][0]), .st_1(st[1][1]), .st_2(st[1][2]), .st_3(st[1][3]),
      .rd_0(rd[1][0]), .rd_1(rd[1][1]), .rd_2(rd[1][2]), .rd_3(rd[1][3]),
      .rnd_idx(rnd_idx[1]), .rnd_en(rnd_en[1]), .last_round(last_round[1]), .busy(busy[1])
   );

   // Round stub: each round XORs the round number into the low nibble of every column.
   for (genvar gw = 0; gw < 2; gw++) begin : g_stub
      for (genvar gk = 0; gk < 4; gk++) begin : g_k
         assign rd[gw][gk] = st[gw][gk] ^ {28'h0, rnd_idx[gw]};
      end
   end

   function automatic int nr_of(input int w);
      return (w == 0) ? 10 : 14;
   endfunction

   // A block's result is the input with every round number 1..NR XORed in.
   function automatic logic [31:0] model_word(input int w, input logic [31:0] x);
      logic [31:0] r;
      r = x;
      for (int i = 1; i <= nr_of(w); i++) r = r ^ 32'(i);
      return r;
   endfunction

   task automatic run_block(input int w, input word4_t din, input int gap_pct, input int stall_pct,
                            input bit inject, input int stall_beat,
                            output word4_t dout, output int lat, output int cycles,
                            output int nrounds, output int idx_tr [16], output bit lr_tr [16],
                            output logic [31:0] held [5], output bit timeout);
      int k     = 0;
      int o     = 0;
      int t_acc = -1;
      int t_out = -1;
      int cyc   = 0;
      int hold  = 0;
      bit hs_in;
      bit hs_out;
      nrounds = 0;
      timeout = 1'b0;
      for (int i = 0; i < 4; i++) dout[i] = '0;
      for (int i = 0; i < 5; i++) held[i] = '0;
      for (int i = 0; i < 16; i++) begin
         idx_tr[i] = 0;
         lr_tr[i]  = 1'b0;
      end
      while (o < 4) begin
         if (k < 4) begin
            in_valid[w] = ($urandom_range(99) >= gap_pct);
            in_data[w]  = din[k];
         end else begin
            in_valid[w] = inject;
            in_data[w]  = 32'hffff_ffff;
         end
         if (o == stall_beat && hold < 5 && out_valid[w]) begin
            out_ready[w] = 1'b0;
            held[hold]   = out_data[w];
            hold++;
         end else begin
            out_ready[w] = ($urandom_range(99) >= stall_pct);
         end
         if (rnd_en[w]) begin
            if (nrounds < 16) begin
               idx_tr[nrounds] = int'(rnd_idx[w]);
               lr_tr[nrounds]  = last_round[w];
            end
            nrounds++;
         end
         if (out_valid[w] && t_out < 0) t_out = cyc;
         hs_in  = in_valid[w] && in_ready[w] && (k < 4);
         hs_out = out_valid[w] && out_ready[w];
         if (hs_out) dout[o] = out_data[w];
         @(posedge clk);
         #1;
         if (hs_in) begin
            if (k == 3) t_acc = cyc;
            k++;
         end
         if (hs_out) o++;
         cyc++;
         if (cyc > 400) begin
            timeout = 1'b1;
            break;
         end
      end
      in_valid[w]  = 1'b0;
      out_ready[w] = 1'b1;
      lat    = t_out - t_acc;
      cycles = cyc;
      $display("blk dut_nr=%0d in=%h %h %h %h out=%h %h %h %h lat=%0d rounds=%0d cycles=%0d",
               nr_of(w), din[0], din[1], din[2], din[3], dout[0], dout[1], dout[2], dout[3],
               lat, nrounds, cycles);
   endtask

   task automatic test_reset();
      for (int w = 0; w < 2; w++) begin
         rst_n[w]     = 1'b0;
         in_valid[w]  = 1'b0;
         out_ready[w] = 1'b1;
         in_data[w]   = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
         checks++;
         if (out_valid[w] !== 1'b0 || rnd_en[w] !== 1'b0 || last_round[w] !== 1'b0 ||
             busy[w] !== 1'b0 || out_data[w] !== 32'h0 || rnd_idx[w] !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs nr=%0d got ov=%b re=%b lr=%b busy=%b od=%h idx=%0d want all 0",
                     nr_of(w), out_valid[w], rnd_en[w], last_round[w], busy[w], out_data[w], rnd_idx[w]);
         end
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (st[w][k] !== 32'h0) begin
               failures++;
               $display("FAIL reset_st nr=%0d col=%0d got %h want 0", nr_of(w), k, st[w][k]);
            end
         end
         rst_n[w] = 1'b1;
      end
      @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
         checks++;
         if (in_ready[w] !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready nr=%0d got %b want 1", nr_of(w), in_ready[w]);
         end
      end
   endtask

   task automatic test_known_vector(input int w);
      word4_t din, dout, exp_w;
      logic [31:0] held [5];
      int idx_tr [16];
      bit lr_tr [16];
      int lat, cycles, nrounds;
      bit timeout;
      int nr;
      nr  = nr_of(w);
      din = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
      if (w == 0) exp_w = '{32'h00112238, 32'h4455667c, 32'h8899aab0, 32'hccddeef4};
      else        exp_w = '{32'h0011223c, 32'h44556678, 32'h8899aab4, 32'hccddeef0};
      run_block(w, din, 0, 0, 1'b0, -1, dout, lat, cycles, nrounds, idx_tr, lr_tr, held, timeout);
      checks++;
      if (timeout) begin
         failures++;
         $display("FAIL known_timeout nr=%0d got timeout want completion", nr);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dout[i] !== exp_w[i]) begin
            failures++;
            $display("FAIL known_out nr=%0d beat=%0d got %h want %h", nr, i, dout[i], exp_w[i]);
         end
      end
      checks++;
      if (lat != nr + 1) begin
         failures++;
         $display("FAIL known_latency nr=%0d got %0d want %0d", nr, lat, nr + 1);
      end
      checks++;
      if (nrounds != nr) begin
         failures++;
         $display("FAIL known_rounds nr=%0d got %0d want %0d", nr, nrounds, nr);
      end
      for (int i = 0; i < nr; i++) begin
         checks++;
         if (idx_tr[i] != i + 1 || lr_tr[i] != (i == nr - 1)) begin
            failures++;
            $display("FAIL known_round_trace nr=%0d commit=%0d got idx=%0d last=%b want idx=%0d last=%b",
                     nr, i, idx_tr[i], lr_tr[i], i + 1, (i == nr - 1));
         end
      end
      checks++;
      if (cycles != nr + 8) begin
         failures++;
         $display("FAIL known_period nr=%0d got %0d want %0d", nr, cycles, nr + 8);
      end
      checks++;
      if (in_ready[w] !== 1'b1 || out_valid[w] !== 1'b0 || busy[w] !== 1'b0) begin
         failures++;
         $display("FAIL known_return_load nr=%0d got rdy=%b ov=%b busy=%b want 1 0 0",
                  nr, in_ready[w], out_valid[w], busy[w]);
      end
   endtask

   task automatic test_backpressure();
      word4_t din, dout;
      logic [31:0] held [5];
      int idx_tr [16];
      bit lr_tr [16];
      int lat, cycles, nrounds;
      bit timeout;
      din = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
      run_block(0, din, 0, 0, 1'b0, 1, dout, lat, cycles, nrounds, idx_tr, lr_tr, held, timeout);
      checks++;
      if (timeout) begin
         failures++;
         $display("FAIL stall_timeout got timeout want completion");
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (held[i] !== 32'h4455667c) begin
            failures++;
            $display("FAIL stall_hold cycle=%0d got %h want 4455667c", i, held[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dout[i] !== model_word(0, din[i])) begin
            failures++;
            $display("FAIL stall_out beat=%0d got %h want %h", i, dout[i], model_word(0, din[i]));
         end
      end
   endtask

   task automatic test_ignore_in_valid();
      word4_t din, dout;
      logic [31:0] held [5];
      int idx_tr [16];
      bit lr_tr [16];
      int lat, cycles, nrounds;
      bit timeout;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 4; i++) din[i] = $urandom;
         run_block(w, din, 0, 20, 1'b1, -1, dout, lat, cycles, nrounds, idx_tr, lr_tr, held, timeout);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (timeout || dout[i] !== model_word(w, din[i])) begin
               failures++;
               $display("FAIL ignore_out nr=%0d beat=%0d got %h want %h timeout=%b",
                        nr_of(w), i, dout[i], model_word(w, din[i]), timeout);
            end
         end
      end
   endtask

   task automatic test_reset_mid_round();
      word4_t din, dout;
      logic [31:0] held [5];
      int idx_tr [16];
      bit lr_tr [16];
      int lat, cycles, nrounds;
      bit timeout;
      int n = 0;
      int seen = 0;
      din = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
      for (int k = 0; k < 4; k++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = din[k];
         @(posedge clk);
         #1;
      end
      in_valid[0] = 1'b0;
      while (rnd_idx[0] != 4'd5 && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (rnd_idx[0] !== 4'd5) begin
         failures++;
         $display("FAIL midreset_reach_round5 got idx=%0d want 5", rnd_idx[0]);
      end
      rst_n[0] = 1'b0;
      @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      checks++;
      if (rnd_idx[0] !== 4'd0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 || rnd_en[0] !== 1'b0) begin
         failures++;
         $display("FAIL midreset_ctrl got idx=%0d busy=%b rdy=%b re=%b want 0 0 1 0",
                  rnd_idx[0], busy[0], in_ready[0], rnd_en[0]);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (st[0][k] !== 32'h0) begin
            failures++;
            $display("FAIL midreset_st col=%0d got %h want 0", k, st[0][k]);
         end
      end
      for (int i = 0; i < 25; i++) begin
         if (out_valid[0]) seen++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL midreset_no_output got %0d out_valid cycles want 0", seen);
      end
      run_block(0, din, 0, 0, 1'b0, -1, dout, lat, cycles, nrounds, idx_tr, lr_tr, held, timeout);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (timeout || dout[i] !== model_word(0, din[i])) begin
            failures++;
            $display("FAIL midreset_next_block beat=%0d got %h want %h timeout=%b",
                     i, dout[i], model_word(0, din[i]), timeout);
         end
      end
   endtask

   task automatic test_random();
      word4_t din, dout;
      logic [31:0] held [5];
      int idx_tr [16];
      bit lr_tr [16];
      int lat, cycles, nrounds;
      bit timeout;
      int w;
      for (int b = 0; b < 12; b++) begin
         w = b % 2;
         for (int i = 0; i < 4; i++) din[i] = $urandom;
         run_block(w, din, 30, 30, (b % 3 == 0), -1, dout, lat, cycles, nrounds,
                   idx_tr, lr_tr, held, timeout);
         checks++;
         if (timeout || nrounds != nr_of(w) || lat != nr_of(w) + 1) begin
            failures++;
            $display("FAIL rand_timing blk=%0d nr=%0d got rounds=%0d lat=%0d timeout=%b want %0d %0d 0",
                     b, nr_of(w), nrounds, lat, timeout, nr_of(w), nr_of(w) + 1);
         end
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout[i] !== model_word(w, din[i])) begin
               failures++;
               $display("FAIL rand_out blk=%0d nr=%0d beat=%0d got %h want %h",
                        b, nr_of(w), i, dout[i], model_word(w, din[i]));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 2; r++) begin
         test_known_vector(0);
         test_known_vector(1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got simulation still running want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_known_vector(0);
      test_known_vector(1);
      test_backpressure();
      test_ignore_in_valid();
      test_reset_mid_round();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
